// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the 16-bit ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_MUL  = 5'b00001,
    OP_SUB  = 5'b00010,
    OP_DIV  = 5'b00011,
    OP_NOT  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_XOR  = 5'b00111,
    OP_INC  = 5'b01000,
    OP_CMP  = 5'b01001,
    OP_RR   = 5'b01010,
    OP_RL   = 5'b01011,
    OP_SETB = 5'b01100,
    OP_CLRB = 5'b01101,
    OP_SETF = 5'b01110,
    OP_SWAP = 5'b01111
  } opcode_e;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_G = 2;
  localparam int unsigned FLG_E = 3;
  localparam int unsigned FLG_N = 6;
  localparam int unsigned FLG_Z = 7;

endpackage

// File: rtl/alu_datapath.sv
// Combinational next-state computation for the ALU result and flag registers.
// Opcodes with MSB set (NOP) fall through to the hold path.
module alu_datapath
  import alu_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [15:0] operand_1,
  input  logic [15:0] operand_2,
  input  logic [3:0]  bit_position,
  input  logic [15:0] cur_result_0,
  input  logic [15:0] cur_result_1,
  input  logic [15:0] cur_flags,
  output logic [15:0] next_result_0,
  output logic [15:0] next_result_1,
  output logic [15:0] next_flags
);

  logic [16:0] sum;
  logic [16:0] diff;
  logic [31:0] prod;
  logic [15:0] bit_mask;
  logic        update_flags;
  logic        c, v, g, e, n, z;

  assign sum      = {1'b0, operand_1} + {1'b0, operand_2};
  assign diff     = {1'b0, operand_1} - {1'b0, operand_2};
  assign prod     = {16'h0000, operand_1} * {16'h0000, operand_2};
  assign bit_mask = 16'h0001 << bit_position;

  // Select results and arithmetic flags per opcode, then fold into the flag word.
  always_comb begin
    next_result_0 = cur_result_0;
    next_result_1 = '0;
    update_flags  = 1'b1;
    c = 1'b0;
    v = 1'b0;
    g = 1'b0;
    e = 1'b0;
    case (opcode)
      OP_ADD: begin
        next_result_0 = sum[15:0];
        c = sum[16];
        v = (operand_1[15] == operand_2[15]) && (sum[15] != operand_1[15]);
      end
      OP_MUL: begin
        next_result_0 = prod[15:0];
        next_result_1 = prod[31:16];
        c = (prod[31:16] != '0);
        v = (prod[31:16] != '0);
      end
      OP_SUB: begin
        next_result_0 = diff[15:0];
        c = diff[16];
        v = (operand_1[15] != operand_2[15]) && (diff[15] != operand_1[15]);
      end
      OP_DIV: begin
        if (operand_2 == '0) begin
          next_result_0 = '1;
          next_result_1 = operand_1;
          v = 1'b1;
        end else begin
          next_result_0 = operand_1 / operand_2;
          next_result_1 = operand_1 % operand_2;
        end
      end
      OP_NOT:  next_result_0 = ~operand_1;
      OP_AND:  next_result_0 = operand_1 & operand_2;
      OP_OR:   next_result_0 = operand_1 | operand_2;
      OP_XOR:  next_result_0 = operand_1 ^ operand_2;
      OP_INC: begin
        next_result_0 = operand_1 + 16'h0001;
        c = (operand_1 == '1);
        v = (operand_1 == '1);
      end
      OP_CMP: begin
        next_result_1 = cur_result_1;
        c = diff[16];
        e = (diff[15:0] == '0);
        g = !diff[16] && (diff[15:0] != '0);
      end
      OP_RR: begin
        next_result_0 = {operand_1[0], operand_1[15:1]};
        c = operand_1[0];
      end
      OP_RL: begin
        next_result_0 = {operand_1[14:0], operand_1[15]};
        c = operand_1[15];
      end
      OP_SETB: next_result_0 = operand_1 | bit_mask;
      OP_CLRB: next_result_0 = operand_1 & ~bit_mask;
      OP_SWAP: next_result_0 = {operand_1[7:0], operand_1[15:8]};
      default: begin
        next_result_1 = cur_result_1;
        update_flags  = 1'b0;
      end
    endcase

    if (opcode == OP_CMP) begin
      n = diff[15];
      z = e;
    end else begin
      n = next_result_0[15];
      z = (next_result_0 == '0);
    end

    next_flags = cur_flags;
    if (opcode == OP_SETF) begin
      next_flags[bit_position] = 1'b1;
    end else if (update_flags) begin
      next_flags[FLG_C] = c;
      next_flags[FLG_V] = v;
      next_flags[FLG_G] = g;
      next_flags[FLG_E] = e;
      next_flags[FLG_N] = n;
      next_flags[FLG_Z] = z;
    end
  end

endmodule

// File: rtl/alu.sv
// 16-bit registered ALU: output registers with asynchronous active-low reset.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic [15:0] operand_1,
  input  logic [15:0] operand_2,
  input  logic [3:0]  bit_position,
  output logic [15:0] result_0,
  output logic [15:0] result_1,
  output logic [15:0] flag_reg
);

  logic [15:0] next_result_0;
  logic [15:0] next_result_1;
  logic [15:0] next_flags;

  alu_datapath u_datapath (
    .opcode        (opcode),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .bit_position  (bit_position),
    .cur_result_0  (result_0),
    .cur_result_1  (result_1),
    .cur_flags     (flag_reg),
    .next_result_0 (next_result_0),
    .next_result_1 (next_result_1),
    .next_flags    (next_flags)
  );

  // Capture the datapath outputs every cycle; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_0 <= '0;
      result_1 <= '0;
      flag_reg <= '0;
    end else begin
      result_0 <= next_result_0;
      result_1 <= next_result_1;
      flag_reg <= next_flags;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, an integer-arithmetic reference
// model checked every cycle, and literal expectations for hand-computed cases.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  opcode = '0;
  logic [15:0] operand_1 = '0;
  logic [15:0] operand_2 = '0;
  logic [3:0]  bit_position = '0;
  logic [15:0] result_0;
  logic [15:0] result_1;
  logic [15:0] flag_reg;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_r0 = '0;
  logic [15:0] m_r1 = '0;
  logic [15:0] m_f  = '0;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .operand_1    (operand_1),
    .operand_2    (operand_2),
    .bit_position (bit_position),
    .result_0     (result_0),
    .result_1     (result_1),
    .flag_reg     (flag_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_r0 = '0;
    m_r1 = '0;
    m_f  = '0;
  endtask

  // Reference behaviour from the operation table, using plain integer arithmetic.
  task automatic model_step(input logic [4:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [3:0] bp);
    int ua, ub, sa, sb, t;
    longint p;
    logic [15:0] r0, r1;
    logic c, v, g, e, n, z;
    ua = a; ub = b;
    sa = int'($signed(a)); sb = int'($signed(b));
    r0 = m_r0; r1 = 16'h0000;
    c = 0; v = 0; g = 0; e = 0;
    if (op >= 5'd16) return;
    if (op == 5'd14) begin
      m_f[bp] = 1'b1;
      return;
    end
    case (op)
      5'd0: begin
        t = ua + ub; r0 = t[15:0]; c = (t > 65535);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      5'd1: begin
        p = longint'(ua) * longint'(ub);
        r0 = p[15:0]; r1 = p[31:16]; c = (r1 != 0); v = c;
      end
      5'd2: begin
        t = ua - ub; r0 = t[15:0]; c = (ua < ub);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      5'd3: begin
        if (ub == 0) begin r0 = 16'hFFFF; r1 = a; v = 1; end
        else begin t = ua / ub; r0 = t[15:0]; t = ua % ub; r1 = t[15:0]; end
      end
      5'd4: begin t = 65535 - ua; r0 = t[15:0]; end
      5'd5: begin t = ua & ub; r0 = t[15:0]; end
      5'd6: begin t = ua | ub; r0 = t[15:0]; end
      5'd7: begin t = ua ^ ub; r0 = t[15:0]; end
      5'd8: begin t = (ua + 1) % 65536; r0 = t[15:0]; c = (ua == 65535); v = c; end
      5'd9: begin
        r1 = m_r1; c = (ua < ub); g = (ua > ub); e = (ua == ub);
      end
      5'd10: begin t = (ua / 2) + (ua % 2) * 32768; r0 = t[15:0]; c = (ua % 2 == 1); end
      5'd11: begin t = (ua * 2) % 65536 + ua / 32768; r0 = t[15:0]; c = (ua >= 32768); end
      5'd12: begin t = ua | (1 << bp); r0 = t[15:0]; end
      5'd13: begin t = ua & ~(1 << bp); r0 = t[15:0]; end
      default: begin t = (ua % 256) * 256 + ua / 256; r0 = t[15:0]; end
    endcase
    if (op == 5'd9) begin
      t = ua - ub; n = t[15]; z = e;
    end else begin
      n = r0[15]; z = (r0 == 16'h0000);
    end
    m_r0 = r0;
    m_r1 = r1;
    m_f  = {m_f[15:8], z, n, m_f[5:4], e, g, v, c};
  endtask

  // Per-cycle comparison of all outputs against the reference model.
  always @(posedge clk) begin
    logic rst_s;
    logic [4:0] op_s;
    logic [15:0] a_s, b_s;
    logic [3:0] bp_s;
    rst_s = rst_n; op_s = opcode; a_s = operand_1; b_s = operand_2; bp_s = bit_position;
    #1;
    if (!rst_s) model_reset();
    else model_step(op_s, a_s, b_s, bp_s);
    check("model_r0", result_0, m_r0);
    check("model_r1", result_1, m_r1);
    check("model_flags", flag_reg, m_f);
  end

  always @(negedge rst_n) model_reset();

  task automatic apply(input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] bp);
    @(negedge clk);
    opcode = op; operand_1 = a; operand_2 = b; bit_position = bp;
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  bp;
  } vec_t;

  vec_t extra[$];

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_r0", result_0, 16'h0000);
    check("reset_r1", result_1, 16'h0000);
    check("reset_flags", flag_reg, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply(5'd0, 16'h000A, 16'h0014, 4'd0);
    check("add_small_r0", result_0, 16'h001E);
    check("add_small_c", {15'b0, flag_reg[0]}, 16'h0000);
    apply(5'd0, 16'hFFFF, 16'h0001, 4'd0);
    check("add_wrap_r0", result_0, 16'h0000);
    check("add_wrap_c", {15'b0, flag_reg[0]}, 16'h0001);
    check("add_wrap_z", {15'b0, flag_reg[7]}, 16'h0001);
    apply(5'd0, 16'h7FFF, 16'h7FFF, 4'd0);
    check("add_ovf_r0", result_0, 16'hFFFE);
    check("add_ovf_flags", flag_reg, 16'h0042);
    apply(5'd1, 16'hFFFF, 16'h0002, 4'd0);
    check("mul_r0", result_0, 16'hFFFE);
    check("mul_r1", result_1, 16'h0001);
    apply(5'd3, 16'd20, 16'd5, 4'd0);
    check("div_r0", result_0, 16'h0004);
    check("div_r1", result_1, 16'h0000);
    apply(5'd3, 16'd20, 16'd0, 4'd0);
    check("div0_r0", result_0, 16'hFFFF);
    check("div0_r1", result_1, 16'h0014);
    check("div0_v", {15'b0, flag_reg[1]}, 16'h0001);
    apply(5'd9, 16'd10, 16'd10, 4'd0);
    check("cmp_eq_e", {15'b0, flag_reg[3]}, 16'h0001);
    check("cmp_hold_r0", result_0, 16'hFFFF);
    check("cmp_hold_r1", result_1, 16'h0014);
    apply(5'd9, 16'd20, 16'd10, 4'd0);
    check("cmp_gt_g", {15'b0, flag_reg[2]}, 16'h0001);
    apply(5'd9, 16'd10, 16'd20, 4'd0);
    check("cmp_lt_c", {15'b0, flag_reg[0]}, 16'h0001);
    apply(5'd10, 16'hAAAA, 16'h0000, 4'd0);
    check("rr_r0", result_0, 16'h5555);
    apply(5'd11, 16'hAAAA, 16'h0000, 4'd0);
    check("rl_r0", result_0, 16'h5555);
    check("rl_c", {15'b0, flag_reg[0]}, 16'h0001);
    apply(5'd15, 16'h1234, 16'h0000, 4'd0);
    check("swap_r0", result_0, 16'h3412);
    apply(5'd12, 16'h0000, 16'h0000, 4'd8);
    check("setb_r0", result_0, 16'h0100);
    apply(5'd13, 16'hFFFF, 16'h0000, 4'd8);
    check("clrb_r0", result_0, 16'hFEFF);
    apply(5'd2, 16'h0003, 16'h0005, 4'd0);
    check("sub_wrap_r0", result_0, 16'hFFFE);
    check("sub_wrap_c", {15'b0, flag_reg[0]}, 16'h0001);
    apply(5'd14, 16'h0000, 16'h0000, 4'd0);
    check("setf0", {15'b0, flag_reg[0]}, 16'h0001);
    apply(5'd14, 16'h0000, 16'h0000, 4'd7);
    check("setf7", {15'b0, flag_reg[7]}, 16'h0001);
    apply(5'd14, 16'h0000, 16'h0000, 4'd6);
    check("setf6", {15'b0, flag_reg[6]}, 16'h0001);
    apply(5'd14, 16'h0000, 16'h0000, 4'd4);
    check("setf4", {15'b0, flag_reg[4]}, 16'h0001);
    apply(5'd14, 16'h0000, 16'h0000, 4'd12);
    apply(5'd0, 16'h0001, 16'h0001, 4'd0);
    check("gp_keep_r0", result_0, 16'h0002);
    check("gp_keep_flags", flag_reg, 16'h1010);

    extra.push_back('{5'd2, 16'h8000, 16'h0001, 4'd0});
    extra.push_back('{5'd1, 16'h1234, 16'h0010, 4'd0});
    extra.push_back('{5'd1, 16'hFFFF, 16'hFFFF, 4'd0});
    extra.push_back('{5'd3, 16'hFFFF, 16'h0007, 4'd0});
    extra.push_back('{5'd8, 16'hFFFF, 16'h0000, 4'd0});
    extra.push_back('{5'd8, 16'h7FFF, 16'h0000, 4'd0});
    extra.push_back('{5'd4, 16'h00FF, 16'h0000, 4'd0});
    extra.push_back('{5'd5, 16'hF0F0, 16'h3C3C, 4'd0});
    extra.push_back('{5'd6, 16'hF0F0, 16'h3C3C, 4'd0});
    extra.push_back('{5'd7, 16'hF0F0, 16'h3C3C, 4'd0});
    extra.push_back('{5'd10, 16'h0001, 16'h0000, 4'd0});
    extra.push_back('{5'd11, 16'h8000, 16'h0000, 4'd0});
    extra.push_back('{5'd12, 16'h0000, 16'h0000, 4'd15});
    extra.push_back('{5'd13, 16'hFFFF, 16'h0000, 4'd0});
    extra.push_back('{5'd9, 16'h8000, 16'h0001, 4'd0});
    extra.push_back('{5'd21, 16'h1111, 16'h2222, 4'd3});
    extra.push_back('{5'd31, 16'h0000, 16'h0000, 4'd9});
    extra.push_back('{5'd0, 16'h8000, 16'h8000, 4'd0});
    foreach (extra[i]) apply(extra[i].op, extra[i].a, extra[i].b, extra[i].bp);

    apply(5'd8, 16'hFFFF, 16'h0000, 4'd0);
    check("inc_wrap_r0", result_0, 16'h0000);
    check("inc_wrap_cv", {14'b0, flag_reg[1:0]}, 16'h0003);
    apply(5'd16, 16'h1234, 16'h5678, 4'd0);
    check("nop_hold_r0", result_0, 16'h0000);

    apply(5'd0, 16'h1234, 16'h1111, 4'd0);
    check("pre_reset_r0", result_0, 16'h2345);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_r0", result_0, 16'h0000);
    check("async_reset_r1", result_1, 16'h0000);
    check("async_reset_flags", flag_reg, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply(5'd7, 16'h00FF, 16'h0F0F, 4'd0);
    check("post_reset_r0", result_0, 16'h0FF0);

    repeat (2) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
